riscv_mc_ctrl: RTL

Multi-cycle control unit for the RV32I core, the next generation of the single-cycle control path. It sequences each instruction over several cycles through a shared instruction/data memory port using a req/ack handshake. The memory wait limit is parametrised, and a bus timeout or an illegal opcode drives the core into a sticky trap. The unit sits beside the datapath (PC, IR, OldPC, ALUOut and Data registers, plus the operand muxes) and also counts retired instructions.

---
 rtl/riscv_pkg.sv | 65 ++++++
 rtl/riscv_imm_decode.sv | 22 ++
 rtl/riscv_mc_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I control paths.
// Holds the opcode constants, the multi-cycle FSM state type, the datapath
// mux-select encodings and the trap cause codes.
package riscv_pkg;

   // Opcodes (IR[6:0])
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [3:0] {
      StIdle,
      StFetch,
      StDecode,
      StMemAdr,
      StMemRd,
      StMemWb,
      StMemWr,
      StExecR,
      StExecI,
      StAluWb,
      StBeq,
      StJal,
      StTrap
   } state_e;

   // result_src
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // alu_src_a
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   // alu_src_b
   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // alu_op
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   // imm_src
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // trap_cause
   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   function automatic logic is_req_state(state_e s);
      return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
   endfunction

endpackage

// File: rtl/riscv_imm_decode.sv
// Immediate-format decode shared by the single- and multi-cycle control paths.
// Ports:
//   op_i       IR[6:0]
//   imm_src_o  immediate format select (I, S, B, J)
module riscv_imm_decode
   import riscv_pkg::*;
(
   input  logic [6:0] op_i,
   output logic [1:0] imm_src_o
);

   always_comb begin
      imm_src_o = IMM_I;
      case (op_i)
         OP_SW:   imm_src_o = IMM_S;
         OP_BEQ:  imm_src_o = IMM_B;
         OP_JAL:  imm_src_o = IMM_J;
         default: imm_src_o = IMM_I;
      endcase
   end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32I control unit.
// Sequences each instruction through a shared memory port (req/ack), traps
// stickily on an illegal opcode or a memory wait longer than MEM_TIMEOUT, and
// counts retired instructions.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   op, zero, mem_ack    opcode, ALU zero flag, memory completion
//   mem_req, mem_we      memory request / write
//   adr_src, ir_write, pc_write, reg_write, result_src,
//   alu_src_a, alu_src_b, alu_op, imm_src   datapath controls
//   trap, trap_cause     sticky trap flag and its cause
//   instret              retired-instruction count
module riscv_mc_ctrl
   import riscv_pkg::*;
#(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned TMO_W       = 8,
   parameter int unsigned MEM_TIMEOUT = 200
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       op,
   input  logic             zero,
   input  logic             mem_ack,
   output logic             mem_req,
   output logic             mem_we,
   output logic             adr_src,
   output logic             ir_write,
   output logic             pc_write,
   output logic             reg_write,
   output logic [1:0]       result_src,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       imm_src,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] instret
);

   localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

   state_e           state_q, state_d;
   logic [TMO_W-1:0] wait_q, wait_d, wait_inc;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             trap_q, trap_d;
   logic [1:0]       cause_q, cause_d;

   riscv_imm_decode u_imm_decode (
      .op_i      (op),
      .imm_src_o (imm_src)
   );

   assign wait_inc = wait_q + TMO_W'(1);

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      instret_d = instret_q;
      trap_d    = trap_q;
      cause_d   = cause_q;

      unique case (state_q)
         StIdle: state_d = StFetch;
         StFetch, StMemRd, StMemWr: begin
            // An ack in the cycle the count would hit the limit still wins.
            if (mem_ack) begin
               unique case (state_q)
                  StFetch: state_d = StDecode;
                  StMemRd: state_d = StMemWb;
                  default: state_d = StFetch;
               endcase
            end else begin
               wait_d = wait_inc;
               if (wait_inc == TMO_LIMIT) begin
                  state_d = StTrap;
                  cause_d = CAUSE_TIMEOUT;
               end
            end
         end
         StDecode: begin
            unique case (op)
               OP_LW, OP_SW: state_d = StMemAdr;
               OP_R:         state_d = StExecR;
               OP_I:         state_d = StExecI;
               OP_BEQ:       state_d = StBeq;
               OP_JAL:       state_d = StJal;
               default: begin
                  state_d = StTrap;
                  cause_d = CAUSE_ILLEGAL;
               end
            endcase
         end
         StMemAdr: state_d = (op == OP_LW) ? StMemRd : StMemWr;
         StMemWb:  state_d = StFetch;
         StExecR:  state_d = StAluWb;
         StExecI:  state_d = StAluWb;
         StAluWb:  state_d = StFetch;
         StBeq:    state_d = StFetch;
         StJal:    state_d = StAluWb;
         default:  state_d = StTrap;
      endcase

      // Every state change restarts the wait count, so each request state is
      // entered with a cleared counter.
      if (state_d != state_q) begin
         wait_d = '0;
      end
      if (state_d == StTrap) begin
         trap_d = 1'b1;
      end
      // Retirement is any return to FETCH after an instruction body.
      if ((state_d == StFetch) && (state_q != StIdle) && (state_q != StFetch)) begin
         instret_d = instret_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         wait_q    <= '0;
         instret_q <= '0;
         trap_q    <= 1'b0;
         cause_q   <= CAUSE_NONE;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         instret_q <= instret_d;
         trap_q    <= trap_d;
         cause_q   <= cause_d;
      end
   end

   // Moore decode of the state register; only ir_write/pc_write see inputs.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RD2;
      alu_op     = ALU_ADD;
      unique case (state_q)
         StFetch: begin
            mem_req    = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            ir_write   = mem_ack;
            pc_write   = mem_ack;
         end
         StDecode: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
         end
         StMemAdr: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_IMM;
         end
         StMemRd: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
         end
         StMemWb: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
         end
         StMemWr: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            adr_src = 1'b1;
         end
         StExecR: begin
            alu_src_a = SRCA_RD1;
            alu_op    = ALU_FUNCT;
         end
         StExecI: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_FUNCT;
         end
         StAluWb: reg_write = 1'b1;
         StBeq: begin
            alu_src_a = SRCA_RD1;
            alu_op    = ALU_SUB;
            pc_write  = zero;
         end
         StJal: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pc_write  = 1'b1;
         end
         default: ;
      endcase
   end

   assign trap       = trap_q;
   assign trap_cause = cause_q;
   assign instret    = instret_q;

endmodule
